// File: rtl/logic_op_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// The op function is defined per bit. Because every op is bitwise,
// callers apply it lane by lane, so it works for any operand width.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_PASA = 3'b110,
    OP_NOTA = 3'b111
  } op_e;

  // One result bit from one bit of a and one bit of b.
  function automatic logic logic_op_f(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASA: r = a;
      OP_NOTA: r = ~a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_pipe_stage.sv
// logic_op_stage: one register slice of the logic_op_pipe pipeline.
// The slice holds valid, data and a zero flag.
// It loads whenever it is empty or its downstream neighbour is taking
// the current beat. The ready chain is therefore bubble-collapsing.
module logic_op_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_zero,
  input  logic             nxt_rdy,
  output logic             rdy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             zero_q,  zero_d;

  // Ready chain and next state.
  // Data only moves with a valid beat, so the output holds its last value while empty.
  always_comb begin
    rdy     = !valid_q || nxt_rdy;
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    if (rdy) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        zero_d = in_zero;
      end
    end
  end

  // Slice registers; reset clears any in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_zero  = zero_q;

endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: pipelined bitwise logic unit with valid/ready flow control.
// Each result takes PIPE_DEPTH register stages. The unit sustains one beat
// per cycle and holds up to PIPE_DEPTH beats under back-pressure.
// Optional feature macro LOGIC_OP_CNT_EN adds the txn_count port and
// parameter CNT_W. That port counts completed results and wraps.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PIPE_DEPTH = 2
`ifdef LOGIC_OP_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero
`ifdef LOGIC_OP_CNT_EN
  ,
  output logic [CNT_W-1:0] txn_count
`endif
);

  logic [WIDTH-1:0] s0_data;
  logic             s0_zero;

  // Op decode.
  // The function and the zero flag are computed here, so later stages only carry bits.
  always_comb begin
    s0_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s0_data[i] = logic_op_f(op_e'(op), a[i], b[i]);
    end
    s0_zero = (s0_data == '0);
  end

  // Stage chain.
  // Each stage pulls valid/data from its upstream neighbour and ready from its
  // downstream neighbour. Per-stage nets avoid a self-referencing chain vector.
  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    logic             v_in, z_in, nxt, rdy_o, v_o, z_o;
    logic [WIDTH-1:0] d_in, d_o;

    if (i == 0) begin : g_first
      assign v_in = in_valid;
      assign d_in = s0_data;
      assign z_in = s0_zero;
    end else begin : g_mid_in
      assign v_in = g_stage[i-1].v_o;
      assign d_in = g_stage[i-1].d_o;
      assign z_in = g_stage[i-1].z_o;
    end

    if (i == PIPE_DEPTH - 1) begin : g_last
      assign nxt = out_ready;
    end else begin : g_mid_rdy
      assign nxt = g_stage[i+1].rdy_o;
    end

    logic_op_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_in),
      .in_data   (d_in),
      .in_zero   (z_in),
      .nxt_rdy   (nxt),
      .rdy       (rdy_o),
      .out_valid (v_o),
      .out_data  (d_o),
      .out_zero  (z_o)
    );
  end

  assign in_ready  = g_stage[0].rdy_o;
  assign out_valid = g_stage[PIPE_DEPTH-1].v_o;
  assign y         = g_stage[PIPE_DEPTH-1].d_o;
  assign y_zero    = g_stage[PIPE_DEPTH-1].z_o;

`ifdef LOGIC_OP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Completion counter: one increment per out handshake, wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe (WIDTH=8, PIPE_DEPTH=2).
// The driver pushes the expected result for each accepted beat.
// The monitor pops and compares on every completed output beat.
module tb_logic_op_pipe;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         y_zero;

`ifdef LOGIC_OP_CNT_EN
  logic [3:0] txn_count;
  logic_op_pipe #(.WIDTH(W), .PIPE_DEPTH(D), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .y_zero(y_zero), .txn_count(txn_count)
  );
`else
  logic_op_pipe #(.WIDTH(W), .PIPE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .y_zero(y_zero)
  );
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit lat_chk = 1'b0;

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    int           c;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Independent reference for random streaming
  function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return x;
      default: return ~x;
    endcase
  endfunction

  task automatic push(input logic [W-1:0] ey);
    exp_q.push_back('{y: ey, z: (ey == '0), c: cyc});
  endtask

  // Monitor: every completed beat is compared in order
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got y=%0h with empty scoreboard (cycle %0d)", y, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("y", 32'(y), 32'(mon_e.y));
        chk("y_zero", 32'(y_zero), 32'(mon_e.z));
        if (lat_chk) chk("latency", 32'(cyc - mon_e.c), 32'(D));
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                      input logic [W-1:0] ey);
    bit done = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = z;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        push(ey);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Random valid/ready streaming of n beats
  task automatic stream(input int n);
    int unsigned r;
    logic [2:0]   o;
    logic [W-1:0] x, z;
    int  sent = 0;
    bit  have = 1'b0;
    for (int t = 0; t < 5000 && sent < n; t++) begin
      if (!have) begin
        r = $urandom; o = r[2:0];
        r = $urandom; x = r[7:0];
        r = $urandom; z = r[7:0];
        have = 1'b1;
      end
      r = $urandom;
      in_valid = r[0]; out_ready = r[1];
      op = o; a = x; b = z;
      @(negedge clk);
      if (in_valid && in_ready) begin
        push(ref_f(o, x, z));
        have = 1'b0;
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_y_zero", 32'(y_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_OP_CNT_EN
    chk("rst_txn_count", 32'(txn_count), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Truth table, F0 op CC, latency D with out_ready held high
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(3'd0, 8'hF0, 8'hCC, 8'hC0);
    send(3'd1, 8'hF0, 8'hCC, 8'hFC);
    send(3'd2, 8'hF0, 8'hCC, 8'h3F);
    send(3'd3, 8'hF0, 8'hCC, 8'h03);
    send(3'd4, 8'hF0, 8'hCC, 8'h3C);
    send(3'd5, 8'hF0, 8'hCC, 8'hC3);
    send(3'd6, 8'hF0, 8'hCC, 8'hF0);
    send(3'd7, 8'hF0, 8'hCC, 8'h0F);

    // Zero flag
    send(3'd0, 8'hAA, 8'h55, 8'h00);
    send(3'd1, 8'hAA, 8'h55, 8'hFF);
    drain();
    lat_chk = 1'b0;

    // Back-pressure: two beats fill the pipe, the third is refused
    out_ready = 1'b0;
    send(3'd4, 8'h11, 8'h22, 8'h33);
    send(3'd0, 8'h0F, 8'h3C, 8'h0C);
    in_valid = 1'b1; op = 3'd1; a = 8'h01; b = 8'h80;
    repeat (2) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("full_accept_on_drain", 32'(in_ready), 32'd1);
        if (in_ready) push(8'h81);
      end
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      if (k == 0) in_valid = 1'b0;
    end
    drain();

    // Random streaming
    stream(100);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(3'd6, 8'h5A, 8'h00, 8'h5A);
    send(3'd7, 8'h5A, 8'h00, 8'hA5);
    rst = 1'b1;
    #1;
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(3'd2, 8'hFF, 8'hFF, 8'h00);
    drain();
    lat_chk = 1'b0;

`ifdef LOGIC_OP_CNT_EN
    // Counter wrap: 17 completions with random stalls on a 4-bit counter
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("cnt_after_rst", 32'(txn_count), 32'd0);
    stream(17);
    drain();
    chk("cnt_wrap", 32'(txn_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
